rtc_sync_counter: RTL and testbench
===================================

# rtc_sync_counter

Single-clock, parametrised real-time clock core that counts seconds, minutes and hours in BCD from a prescaled system clock. It replaces ripple-clocked digit counters with one synchronous clock-enable chain. It adds run/pause, a validated time-load port, a one-second pulse, and selectable 12/24-hour presentation with a PM flag. It feeds the 7-segment decoders and any software-visible time registers.

## Interface
- `TICK_DIV`, default 50000000: CLK cycles per second; legal range ≥ 2.
- `PW`, default `$clog2(TICK_DIV)`: prescaler width; derived, do not override.
- `CLK`, in, 1: system clock; all state updates on rising edge.
- `RST`, in, 1: reset, synchronous and active-high.
- `RUN`, in, 1: 1 = prescaler and time advance; 0 = frozen (prescaler holds).
- `FMT24`, in, 1: 1 = 24-hour presentation; 0 = 12-hour presentation.
- `LOAD`, in, 1: one-cycle strobe to load time.
- `LOAD_HH`, `LOAD_MM`, `LOAD_SS`, in, 8 each: load value, packed BCD {tens,units}, always 24-hour.
- `LOAD_ERR`, out, 1: one-cycle pulse when a load is rejected.
- `SEC_PULSE`, out, 1: one-cycle pulse on every seconds increment.
- `HR_M`, `HR_L`, `MIN_M`, `MIN_L`, `SEC_M`, `SEC_L`, out, 4 each: BCD digits for display.
- `PM`, out, 1: 1 when internal hour ≥ 12, in either format.

## Operation
- Internal time is always 24-hour packed BCD: hh 00–23, mm 00–59, ss 00–59. The prescaler counts 0..TICK_DIV-1.
- **Tick:** `RUN`=1 and prescaler = TICK_DIV-1. On a tick:
  - the prescaler returns to 0;
  - ss increments;
  - 59 wraps to 00 and carries into mm;
  - mm 59 wraps and carries into hh;
  - hh 23 wraps to 00.
- All digit updates happen in the same edge. No derived or gated clocks.
- **Load:** accepted when every digit is BCD (≤9) and hh≤23, mm≤59, ss≤59.
  - Accepted load: the time registers take the load value and the prescaler clears to 0.
  - Rejected load: no state changes and `LOAD_ERR`=1 next cycle.
- **Priority per edge:** `RST` > `LOAD` > tick. A load coinciding with a tick wins; that tick is discarded and `SEC_PULSE` stays 0.
- `RUN`=0 does not block `LOAD`.
- **Presentation** is combinational from the registers:
  - `FMT24`=1: hour digits = internal hh.
  - `FMT24`=0: internal hh 00 shows 12; 01–12 show as is; 13–23 show hh−12 in BCD. So 13→01, 20→08, 23→11.
  - `FMT24` can change at any time with no effect on stored time.
- **Reset values:** time 00:00:00, prescaler 0, `SEC_PULSE`=0, `LOAD_ERR`=0, `PM`=0.
  - `HR_M`/`HR_L` read 0/0 if `FMT24`=1, or 1/2 if `FMT24`=0.
- **Reset mid-load or mid-count:** reset wins and no pulse is emitted.

## Timing
- Time registers update on the edge where a tick or accepted `LOAD` is sampled. Digit outputs reflect the new value immediately after that edge (zero added latency; outputs are combinational from registers).
- `SEC_PULSE` is registered and high during the cycle after the tick edge. This puts it coincident with the new ss value. It is never high two consecutive cycles when TICK_DIV ≥ 2.
- `LOAD_ERR` is registered and high for exactly one cycle, the cycle after the rejected `LOAD` edge.
- **First tick after reset or accepted load:** exactly TICK_DIV cycles later when `RUN` is held 1.
- **Pause:** deasserting `RUN` freezes the prescaler mid-count. Reasserting resumes from the frozen value, so no partial second is lost or gained.

## Configuration
- `RTC_ALARM_EN` defined adds the following:
  - inputs `ALM_SET` (1), `ALM_HH`, `ALM_MM` (8 each, 24-hour BCD);
  - input `ALM_CLR` (1);
  - outputs `ALM_ACT` (1) and `ALM_ARMED` (1).
- `ALM_SET` with valid values stores the alarm and sets `ALM_ARMED`. Invalid values are ignored and raise `LOAD_ERR`.
- When a tick moves time to exactly ALM_HH:ALM_MM:00 while armed, `ALM_ACT` goes high the same cycle as `SEC_PULSE`. It stays high until `ALM_CLR` or `RST`.
- An accepted `LOAD` to exactly the alarm time does not fire the alarm.
- Reset values: alarm 00:00, `ALM_ARMED`=0, `ALM_ACT`=0.
- Without the macro, none of these ports or registers exist.

## Test plan
All scenarios use TICK_DIV=4.
1. **Reset and first tick:** reset, `RUN`=1, `FMT24`=1. Expected:
   - digits read 00:00:00;
   - `SEC_PULSE` appears exactly 4 cycles after reset release;
   - SEC_L=1 in that pulse cycle.
2. **Full rollover:** load 23:59:58, `FMT24`=1. Expected:
   - after 2 ticks, 00:00:00 with `PM` 1→0;
   - with `FMT24`=0, display reads 12:00:00.
3. **12-hour mapping:** load 13:05:00 and `FMT24`=0, then load 00:30:00. Expected:
   - 13:05:00 shows HR=01, `PM`=1;
   - 00:30:00 shows HR=12, `PM`=0.
4. **Load validation:**
   - loading 24:00:00 or 12:5A:00 → `LOAD_ERR` one cycle, time unchanged;
   - `LOAD` in the same cycle as a tick → loaded value held, no `SEC_PULSE`, next tick 4 cycles later.
5. **Pause:** drop `RUN` for 10 cycles at prescaler=2. Expected:
   - no ticks during the pause;
   - next tick 2 cycles after `RUN` returns;
   - an accepted `LOAD` during the pause is applied.
6. **Alarm (`RTC_ALARM_EN`):** set alarm 07:00, load 06:59:58. Expected:
   - `ALM_ACT` rises on the 2nd tick and holds until `ALM_CLR`;
   - loading 07:00:00 directly does not assert `ALM_ACT`.

Source files
------------

// File: rtl/rtc_sync_counter_if.sv
// Control, load and display bus of the rtc_sync_counter core.
// Alarm signals are present only when RTC_ALARM_EN is defined.
interface rtc_sync_counter_if;
    logic       RUN;
    logic       FMT24;
    logic       LOAD;
    logic [7:0] LOAD_HH;
    logic [7:0] LOAD_MM;
    logic [7:0] LOAD_SS;
    logic       LOAD_ERR;
    logic       SEC_PULSE;
    logic [3:0] HR_M;
    logic [3:0] HR_L;
    logic [3:0] MIN_M;
    logic [3:0] MIN_L;
    logic [3:0] SEC_M;
    logic [3:0] SEC_L;
    logic       PM;
`ifdef RTC_ALARM_EN
    logic       ALM_SET;
    logic [7:0] ALM_HH;
    logic [7:0] ALM_MM;
    logic       ALM_CLR;
    logic       ALM_ACT;
    logic       ALM_ARMED;

    modport master (
        output RUN, FMT24, LOAD, LOAD_HH, LOAD_MM, LOAD_SS,
        output ALM_SET, ALM_HH, ALM_MM, ALM_CLR,
        input  LOAD_ERR, SEC_PULSE, HR_M, HR_L, MIN_M, MIN_L, SEC_M, SEC_L, PM,
        input  ALM_ACT, ALM_ARMED
    );
    modport slave (
        input  RUN, FMT24, LOAD, LOAD_HH, LOAD_MM, LOAD_SS,
        input  ALM_SET, ALM_HH, ALM_MM, ALM_CLR,
        output LOAD_ERR, SEC_PULSE, HR_M, HR_L, MIN_M, MIN_L, SEC_M, SEC_L, PM,
        output ALM_ACT, ALM_ARMED
    );
`else
    modport master (
        output RUN, FMT24, LOAD, LOAD_HH, LOAD_MM, LOAD_SS,
        input  LOAD_ERR, SEC_PULSE, HR_M, HR_L, MIN_M, MIN_L, SEC_M, SEC_L, PM
    );
    modport slave (
        input  RUN, FMT24, LOAD, LOAD_HH, LOAD_MM, LOAD_SS,
        output LOAD_ERR, SEC_PULSE, HR_M, HR_L, MIN_M, MIN_L, SEC_M, SEC_L, PM
    );
`endif
endinterface

// File: rtl/rtc_sync_counter.sv
// Synchronous BCD real-time clock: prescaler clock-enable chain, validated load, 12/24h display.
// Define RTC_ALARM_EN to add the hh:mm alarm (ALM_* signals on the bus interface).
module rtc_sync_counter #(
    parameter int TICK_DIV = 50000000,
    parameter int PW       = $clog2(TICK_DIV)
) (
    input  logic              CLK,
    input  logic              RST,
    rtc_sync_counter_if.slave bus
);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    function automatic logic [6:0] bcd_to_dec(input logic [7:0] v);
        return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v, input logic [6:0] max_dec);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd_to_dec(v) <= max_dec);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [PW-1:0] r_presc;
    logic [7:0]    r_hh;
    logic [7:0]    r_mm;
    logic [7:0]    r_ss;
    logic          r_sec_pulse;
    logic          r_load_err;

    logic          w_tick;
    logic          w_load_ok;
    logic          w_load_rej;
    logic          w_alm_rej;
    logic [7:0]    w_hh_next;
    logic [7:0]    w_mm_next;
    logic [7:0]    w_ss_next;
    logic [7:0]    w_hr_disp;
    logic [6:0]    w_disp_dec;

    // NOTE: every always_comb output is assigned before any condition, so no latch can be inferred.
    always_comb begin
        w_tick     = bus.RUN && (r_presc == PRESC_LAST);
        w_load_ok  = bcd_ok(bus.LOAD_HH, 7'd23) && bcd_ok(bus.LOAD_MM, 7'd59)
                  && bcd_ok(bus.LOAD_SS, 7'd59);
        w_load_rej = bus.LOAD && !w_load_ok;
        w_ss_next  = bcd_inc(r_ss, 8'h59);
        w_mm_next  = (r_ss == 8'h59) ? bcd_inc(r_mm, 8'h59) : r_mm;
        w_hh_next  = (r_ss == 8'h59 && r_mm == 8'h59) ? bcd_inc(r_hh, 8'h23) : r_hh;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_presc     <= '0;
            r_hh        <= 8'h00;
            r_mm        <= 8'h00;
            r_ss        <= 8'h00;
            r_sec_pulse <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_sec_pulse <= 1'b0;
            r_load_err  <= w_load_rej || w_alm_rej;
            // Any LOAD owns the edge: a coinciding tick is dropped, a rejected load holds everything.
            if (bus.LOAD) begin
                if (w_load_ok) begin
                    r_hh    <= bus.LOAD_HH;
                    r_mm    <= bus.LOAD_MM;
                    r_ss    <= bus.LOAD_SS;
                    r_presc <= '0;
                end
            end else if (w_tick) begin
                r_presc     <= '0;
                r_hh        <= w_hh_next;
                r_mm        <= w_mm_next;
                r_ss        <= w_ss_next;
                r_sec_pulse <= 1'b1;
            end else if (bus.RUN) begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

`ifdef RTC_ALARM_EN
    logic [7:0] r_alm_hh;
    logic [7:0] r_alm_mm;
    logic       r_alm_armed;
    logic       r_alm_act;
    logic       w_alm_ok;
    logic       w_alm_hit;

    always_comb begin
        w_alm_ok  = bcd_ok(bus.ALM_HH, 7'd23) && bcd_ok(bus.ALM_MM, 7'd59);
        w_alm_rej = bus.ALM_SET && !w_alm_ok;
        // Only a real tick can fire; a load landing on the alarm time never does.
        w_alm_hit = r_alm_armed && !bus.LOAD && w_tick && (w_ss_next == 8'h00)
                 && (w_mm_next == r_alm_mm) && (w_hh_next == r_alm_hh);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_alm_hh    <= 8'h00;
            r_alm_mm    <= 8'h00;
            r_alm_armed <= 1'b0;
            r_alm_act   <= 1'b0;
        end else begin
            if (bus.ALM_SET && w_alm_ok) begin
                r_alm_hh    <= bus.ALM_HH;
                r_alm_mm    <= bus.ALM_MM;
                r_alm_armed <= 1'b1;
            end
            if (w_alm_hit)
                r_alm_act <= 1'b1;
            else if (bus.ALM_CLR)
                r_alm_act <= 1'b0;
        end
    end

    assign bus.ALM_ACT   = r_alm_act;
    assign bus.ALM_ARMED = r_alm_armed;
`else
    assign w_alm_rej = 1'b0;
`endif

    // 12-hour view: 00 shows 12, 13..23 show hh-12; stored time is untouched.
    always_comb begin
        w_hr_disp  = r_hh;
        w_disp_dec = 7'd0;
        if (!bus.FMT24) begin
            if (r_hh == 8'h00) begin
                w_hr_disp = 8'h12;
            end else if (r_hh > 8'h12) begin
                w_disp_dec = bcd_to_dec(r_hh) - 7'd12;
                w_hr_disp  = (w_disp_dec >= 7'd10) ? {4'd1, 4'(w_disp_dec - 7'd10)}
                                                   : {4'd0, w_disp_dec[3:0]};
            end
        end
    end

    assign bus.HR_M      = w_hr_disp[7:4];
    assign bus.HR_L      = w_hr_disp[3:0];
    assign bus.MIN_M     = r_mm[7:4];
    assign bus.MIN_L     = r_mm[3:0];
    assign bus.SEC_M     = r_ss[7:4];
    assign bus.SEC_L     = r_ss[3:0];
    assign bus.PM        = (r_hh >= 8'h12);
    assign bus.SEC_PULSE = r_sec_pulse;
    assign bus.LOAD_ERR  = r_load_err;

endmodule

// File: tb/tb_rtc_sync_counter.sv
// Bench for rtc_sync_counter (TICK_DIV=4): seconds-of-day model checked every cycle plus directed literals.
module tb_rtc_sync_counter;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    rtc_sync_counter_if bus ();

    rtc_sync_counter #(.TICK_DIV(TD)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int dec(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit field_ok(input logic [7:0] v, input int max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (dec(v) <= max);
    endfunction

    // Expected output vector from time-of-day in seconds.
    function automatic logic [26:0] expect_vec(input int secs, input bit fmt24, input bit pulse,
                                               input bit err);
        int h, m, s, dh;
        h  = secs / 3600;
        m  = (secs / 60) % 60;
        s  = secs % 60;
        dh = fmt24 ? h : ((h % 12 == 0) ? 12 : h % 12);
        return {4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                (h >= 12), pulse, err};
    endfunction

    int m_secs  = 0;
    int m_cnt   = 0;
    bit m_pulse = 1'b0;
    bit m_err   = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        bit alm_bad;
        alm_bad = 1'b0;
`ifdef RTC_ALARM_EN
        alm_bad = bus.ALM_SET && !(field_ok(bus.ALM_HH, 23) && field_ok(bus.ALM_MM, 59));
`endif
        if (rst) begin
            m_secs  <= 0;
            m_cnt   <= 0;
            m_pulse <= 1'b0;
            m_err   <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            m_pulse <= 1'b0;
            m_err   <= alm_bad;
            if (bus.LOAD) begin
                if (field_ok(bus.LOAD_HH, 23) && field_ok(bus.LOAD_MM, 59) && field_ok(bus.LOAD_SS, 59)) begin
                    m_secs <= dec(bus.LOAD_HH) * 3600 + dec(bus.LOAD_MM) * 60 + dec(bus.LOAD_SS);
                    m_cnt  <= 0;
                end else begin
                    m_err <= 1'b1;
                end
            end else if (bus.RUN) begin
                if (m_cnt == TD - 1) begin
                    m_cnt   <= 0;
                    m_secs  <= (m_secs + 1) % 86400;
                    m_pulse <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid)
            check("model", 32'({bus.HR_M, bus.HR_L, bus.MIN_M, bus.MIN_L, bus.SEC_M, bus.SEC_L,
                                bus.PM, bus.SEC_PULSE, bus.LOAD_ERR}),
                  32'(expect_vec(m_secs, bus.FMT24, m_pulse, m_err)));
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus.LOAD_HH = h;
        bus.LOAD_MM = m;
        bus.LOAD_SS = s;
        bus.LOAD    = 1'b1;
        step();
        bus.LOAD    = 1'b0;
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.SEC_PULSE && n < 20);
        check("pulse_seen", 32'(bus.SEC_PULSE), 32'd1);
    endtask

    function automatic logic [31:0] digits();
        return 32'({bus.HR_M, bus.HR_L, bus.MIN_M, bus.MIN_L, bus.SEC_M, bus.SEC_L});
    endfunction

    initial begin
        int n;
        bus.RUN = 1'b1; bus.FMT24 = 1'b1; bus.LOAD = 1'b0;
        bus.LOAD_HH = 8'h00; bus.LOAD_MM = 8'h00; bus.LOAD_SS = 8'h00;
`ifdef RTC_ALARM_EN
        bus.ALM_SET = 1'b0; bus.ALM_HH = 8'h00; bus.ALM_MM = 8'h00; bus.ALM_CLR = 1'b0;
`endif
        step(2);
        check("reset_digits", digits(), 32'h000000);
        check("reset_flags", 32'({bus.PM, bus.SEC_PULSE, bus.LOAD_ERR}), 32'd0);
        bus.FMT24 = 1'b0; #1;
        check("reset_hr12", 32'({bus.HR_M, bus.HR_L}), 32'h12);
        bus.FMT24 = 1'b1;
        rst = 1'b0;
        wait_pulse(n);
        check("first_tick_latency", 32'(n), 32'd4);
        check("first_tick_sec_l", 32'(bus.SEC_L), 32'd1);
        step();
        check("pulse_one_cycle", 32'(bus.SEC_PULSE), 32'd0);

        do_load(8'h23, 8'h59, 8'h58);
        check("load_rollover_start", digits(), 32'h235958);
        wait_pulse(n);
        check("rollover_tick1", digits(), 32'h235959);
        check("rollover_pm_before", 32'(bus.PM), 32'd1);
        wait_pulse(n);
        check("rollover_midnight", digits(), 32'h000000);
        check("rollover_pm_after", 32'(bus.PM), 32'd0);
        bus.FMT24 = 1'b0; #1;
        check("midnight_12h", digits(), 32'h120000);

        do_load(8'h13, 8'h05, 8'h00);
        check("h13_as_01", digits(), 32'h010500);
        check("h13_pm", 32'(bus.PM), 32'd1);
        do_load(8'h20, 8'h00, 8'h00);
        check("h20_as_08", 32'({bus.HR_M, bus.HR_L}), 32'h08);
        do_load(8'h12, 8'h00, 8'h00);
        check("h12_noon", 32'({bus.HR_M, bus.HR_L, bus.PM}), 32'({8'h12, 1'b1}));
        do_load(8'h00, 8'h30, 8'h00);
        check("h00_as_12", digits(), 32'h123000);
        check("h00_pm", 32'(bus.PM), 32'd0);
        bus.FMT24 = 1'b1;

        do_load(8'h10, 8'h20, 8'h30);
        do_load(8'h24, 8'h00, 8'h00);
        check("rej24_err", 32'(bus.LOAD_ERR), 32'd1);
        check("rej24_time", digits(), 32'h102030);
        step();
        check("rej24_err_drop", 32'(bus.LOAD_ERR), 32'd0);
        do_load(8'h12, 8'h5A, 8'h00);
        check("rej5a_err", 32'(bus.LOAD_ERR), 32'd1);
        check("rej5a_time", digits(), 32'h102030);
        wait_pulse(n);
        step(3);
        do_load(8'h11, 8'h11, 8'h11);
        check("load_on_tick_time", digits(), 32'h111111);
        check("load_on_tick_nopulse", 32'(bus.SEC_PULSE), 32'd0);
        wait_pulse(n);
        check("load_on_tick_next", 32'(n), 32'd4);
        check("load_on_tick_sec", digits(), 32'h111112);

        step(2);
        bus.RUN = 1'b0;
        n = 0;
        repeat (10) begin
            step();
            if (bus.SEC_PULSE) n++;
        end
        check("pause_no_ticks", 32'(n), 32'd0);
        check("pause_time_frozen", digits(), 32'h111112);
        bus.RUN = 1'b1;
        wait_pulse(n);
        check("resume_latency", 32'(n), 32'd2);
        bus.RUN = 1'b0;
        do_load(8'h05, 8'h06, 8'h07);
        check("pause_load", digits(), 32'h050607);
        step(3);
        bus.RUN = 1'b1;
        wait_pulse(n);
        check("pause_load_resume", 32'(n), 32'd4);

`ifdef RTC_ALARM_EN
        bus.ALM_HH = 8'h25; bus.ALM_MM = 8'h00; bus.ALM_SET = 1'b1;
        step();
        bus.ALM_SET = 1'b0;
        check("alm_bad_err", 32'({bus.LOAD_ERR, bus.ALM_ARMED}), 32'b10);
        bus.ALM_HH = 8'h07; bus.ALM_MM = 8'h00; bus.ALM_SET = 1'b1;
        step();
        bus.ALM_SET = 1'b0;
        check("alm_armed", 32'(bus.ALM_ARMED), 32'd1);
        do_load(8'h06, 8'h59, 8'h58);
        wait_pulse(n);
        check("alm_quiet_tick1", 32'(bus.ALM_ACT), 32'd0);
        wait_pulse(n);
        check("alm_fire", 32'({bus.ALM_ACT, bus.SEC_PULSE}), 32'b11);
        check("alm_fire_time", digits(), 32'h070000);
        step(6);
        check("alm_hold", 32'(bus.ALM_ACT), 32'd1);
        bus.ALM_CLR = 1'b1;
        step();
        bus.ALM_CLR = 1'b0;
        check("alm_clr", 32'(bus.ALM_ACT), 32'd0);
        do_load(8'h07, 8'h00, 8'h00);
        step(2);
        check("alm_load_nofire", 32'(bus.ALM_ACT), 32'd0);
`endif

        wait_pulse(n);
        step(3);
        rst = 1'b1;
        step();
        check("reset_midcount_pulse", 32'(bus.SEC_PULSE), 32'd0);
        check("reset_midcount_time", digits(), 32'h000000);
        rst = 1'b0;
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
